// File: rtl/bus_arb_pkg.sv
// Shared constants and helpers for the bus grant arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
// Used by bus_rr_pick and bus_grant_arbiter.
package bus_arb_pkg;

    localparam int NUM_REQ      = 4;
    localparam int SEL_W        = 2;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Round-robin selector: first set request bit scanning upward from last+1, wrapping mod 4.
// Latency: purely combinational. Backpressure: none.
// The previous owner (last) has the lowest priority.
module bus_rr_pick
    import bus_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       any
);

    // Scan from the farthest offset down so the nearest requester after last wins.
    always_comb begin
        winner = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[last + SEL_W'(k)]) begin
                winner = last + SEL_W'(k);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin owner of a four-driver tristate line: one-hot grant, matching sel, dead cycle between owners.
// Latency: grant one edge after req out of IDLE; all outputs registered. ARB_PARK_EN parks grant on the last owner.
// Backpressure: none; waiters hold req, owners past MAX_HOLD are preempted when someone waits.
module bus_grant_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HOLD_W   = 8
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       grant_valid,
    output logic       preempt
);

    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

`ifdef ARB_PARK_EN
    localparam logic [3:0] GRANT_RST = 4'b0001;
    localparam logic       VALID_RST = 1'b1;
`else
    localparam logic [3:0] GRANT_RST = 4'b0000;
    localparam logic       VALID_RST = 1'b0;
`endif

    arb_state_e        state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        last_q, last_d;
    logic [HOLD_W-1:0] count_q, count_d;
    logic              preempt_q, preempt_d;
    logic              grant_valid_q, grant_valid_d;

    logic [1:0]        pick_winner;
    logic              pick_any;

    bus_rr_pick u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        count_d   = count_q;
        preempt_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
`ifdef ARB_PARK_EN
                if (!pick_any) begin
                    grant_d = onehot(sel_q);
                end else if (grant_q != 4'b0000 && pick_winner != sel_q) begin
                    // A different owner must not see the parked driver still enabled.
                    grant_d = 4'b0000;
                end else begin
                    state_d = ST_OWN;
                    grant_d = onehot(pick_winner);
                    sel_d   = pick_winner;
                    last_d  = pick_winner;
                    count_d = '0;
                end
`else
                if (pick_any) begin
                    state_d = ST_OWN;
                    grant_d = onehot(pick_winner);
                    sel_d   = pick_winner;
                    last_d  = pick_winner;
                    count_d = '0;
                end
`endif
            end
            ST_OWN: begin
                count_d = (count_q == HOLD_SAT) ? count_q : count_q + 1'b1;
                if (!req[sel_q]) begin
                    state_d = ST_IDLE;
`ifdef ARB_PARK_EN
                    grant_d = (req == 4'b0000) ? grant_q : 4'b0000;
`else
                    grant_d = 4'b0000;
`endif
                end else if (count_q == HOLD_LAST && (req & ~grant_q) != 4'b0000) begin
                    state_d   = ST_IDLE;
                    grant_d   = 4'b0000;
                    preempt_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase

        grant_valid_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= GRANT_RST;
            sel_q         <= 2'd0;
            last_q        <= 2'd3;
            count_q       <= '0;
            preempt_q     <= 1'b0;
            grant_valid_q <= VALID_RST;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            sel_q         <= sel_d;
            last_q        <= last_d;
            count_q       <= count_d;
            preempt_q     <= preempt_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant       = grant_q;
    assign sel         = sel_q;
    assign grant_valid = grant_valid_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Directed bench for bus_grant_arbiter: two instances (MAX_HOLD 8 and 4) share clk, reset and req.
// Outputs are sampled on the falling edge; inputs change on the falling edge too.
module tb_bus_grant_arbiter;

`ifdef ARB_PARK_EN
    localparam logic PARK = 1'b1;
`else
    localparam logic PARK = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b1111;

    logic [3:0] g4, g8;
    logic [1:0] s4, s8;
    logic       v4, v8, p4, p8;

    int checks = 0;
    int errors = 0;

    bus_grant_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) u4 (
        .clk(clk), .reset(reset), .req(req),
        .grant(g4), .sel(s4), .grant_valid(v4), .preempt(p4)
    );

    bus_grant_arbiter #(.MAX_HOLD(8), .HOLD_W(8)) u8 (
        .clk(clk), .reset(reset), .req(req),
        .grant(g8), .sel(s8), .grant_valid(v8), .preempt(p8)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_one(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic p, input logic [3:0] eg,
                           input logic [1:0] es, input logic ev, input logic ep);
        chk({tag, " grant"}, g, eg);
        chk({tag, " sel"}, {2'b00, s}, {2'b00, es});
        chk({tag, " grant_valid"}, {3'b000, v}, {3'b000, ev});
        chk({tag, " preempt"}, {3'b000, p}, {3'b000, ep});
    endtask

    task automatic chk_both(input string tag, input logic [3:0] eg, input logic [1:0] es,
                            input logic ev, input logic ep);
        chk_one({tag, "/u4"}, g4, s4, v4, p4, eg, es, ev, ep);
        chk_one({tag, "/u8"}, g8, s8, v8, p8, eg, es, ev, ep);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Held-contention model: each period is m owned cycles then one preempt/dead cycle; owners alternate 0,1.
    task automatic chk_pre(input string tag, input int k, input int m, input logic [3:0] g,
                           input logic [1:0] s, input logic v, input logic p);
        int          pos;
        logic [1:0]  own;
        pos = k % (m + 1);
        own = 2'((k / (m + 1)) % 2);
        chk_one(tag, g, s, v, p, (pos < m) ? oh(own) : 4'b0000, own, pos < m, pos == m);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert ($onehot0(g4) && (v4 == |g4) && (!v4 || g4 == oh(s4)) &&
                    $onehot0(g8) && (v8 == |g8) && (!v8 || g8 == oh(s8))) else begin
                errors++;
                $error("FAIL invariant: u4 grant=%b sel=%0d valid=%b u8 grant=%b sel=%0d valid=%b required onehot0 grant matching sel",
                       g4, s4, v4, g8, s8, v8);
            end
        end
    end

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        cyc();
        cyc();
        chk_both("reset", PARK ? 4'b0001 : 4'b0000, 2'd0, PARK, 1'b0);

        reset = 1'b0;
        cyc();
        chk_both("first grant", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifndef ARB_PARK_EN
        for (int i = 0; i < 5; i++) begin
            logic [1:0] o;
            o = 2'(i);
            chk_both("rr own", oh(o), o, 1'b1, 1'b0);
            cyc();
            chk_both("rr hold", oh(o), o, 1'b1, 1'b0);
            req = 4'b1111 & ~oh(o);
            cyc();
            chk_both("rr dead", 4'b0000, o, 1'b0, 1'b0);
            req = 4'b1111;
            cyc();
        end

        req = 4'b0000;
        cyc();
        chk_both("rr release", 4'b0000, 2'd1, 1'b0, 1'b0);

        req = 4'b0100;
        cyc();
        for (int i = 0; i < 20; i++) begin
            chk_both("single", 4'b0100, 2'd2, 1'b1, 1'b0);
            cyc();
        end
        req = 4'b0000;
        cyc();
        chk_both("single release", 4'b0000, 2'd2, 1'b0, 1'b0);

        req = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk_pre("preempt/u4", k, 4, g4, s4, v4, p4);
            chk_pre("preempt/u8", k, 8, g8, s8, v8, p8);
        end
        req = 4'b0000;
        cyc();
        chk_one("preempt end/u4", g4, s4, v4, p4, 4'b0000, 2'd0, 1'b0, 1'b0);
        chk_one("preempt end/u8", g8, s8, v8, p8, 4'b0000, 2'd1, 1'b0, 1'b0);

        req = 4'b1000;
        cyc();
        chk_both("own 3", 4'b1000, 2'd3, 1'b1, 1'b0);
        reset = 1'b1;
        cyc();
        chk_both("reset mid-own", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        req   = 4'b0010;
        cyc();
        chk_both("post reset", 4'b0010, 2'd1, 1'b1, 1'b0);
        reset = 1'b1;
        req   = 4'b0110;
        cyc();
        chk_both("reset again", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc();
        chk_both("last reset to 3", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        req = 4'b0000;
        cyc();
        chk_both("park 0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0100;
        cyc();
        chk_both("park switch dead", 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc();
        chk_both("park own 2", 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc();
        chk_both("park hold 2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        cyc();
        chk_both("park release 2", 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc();
        chk_both("park stay 2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0001;
        cyc();
        chk_both("park to 0 dead", 4'b0000, 2'd2, 1'b0, 1'b0);
        cyc();
        chk_both("park own 0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        cyc();
        chk_both("park on 0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0001;
        cyc();
        chk_both("park direct", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
